wb_gain_scheduler: RTL
======================

Name: wb_gain_scheduler

Overview:
Time-multiplexes one shared 12x12 multiplier across NUM_CH pixel channels (R, Gr/Gb, B) in the white-balance / digital-gain stage of the ISP. A round-robin arbiter grants one channel per cycle. The granted pixel is multiplied by that channel's programmable gain, right-shifted by FRAC_BITS and clamped to [0, 2^WIDTH-1]. The block holds the per-channel gain registers and drives a 2-stage valid/ready pipeline toward the demosaic input.

Parameters:
WIDTH, 12, pixel and gain width in bits
FRAC_BITS, 8, fractional bits of the gain (unsigned Q4.8 with defaults; 0x100 = 1.0)
NUM_CH, 3, number of requesting channels (2..4)
GAIN_RST, 256, reset value of every gain register

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  NUM_CH  per-channel pixel request
in_pixel  input  NUM_CH*WIDTH  packed pixels; channel i at [i*WIDTH +: WIDTH]
in_ready  output  NUM_CH  per-channel accept; one-hot or zero
gain_we  input  1  gain register write strobe
gain_sel  input  2  gain register index
gain_wdata  input  WIDTH  gain value to write
out_valid  output  1  result valid
out_data  output  WIDTH  scaled, clamped pixel
out_ch  output  2  channel index of out_data
out_ready  input  1  downstream accept

Behaviour:
- Reset, asynchronous, rst_n low:
  - out_valid=0, out_data=0, out_ch=0.
  - Stage-1 valid=0. RR pointer=0.
  - All gains=GAIN_RST.
  - in_ready=0 while rst_n is low.
  - Asserting reset mid-operation discards all in-flight results. No output follows the release of reset until new accepts occur.
- Pipeline stall: advance = !(out_valid && !out_ready).
  - Stage 2 loads from stage 1 only when advance=1.
  - Stage 1 loads only when advance=1.
  - This gives a 1-bubble-free 2-deep pipeline with no skid buffer.
- Arbitration (combinational):
  - Scan channels starting at the RR pointer; the first with in_valid=1 gets grant.
  - in_ready[i] = grant[i] & advance.
- Accept: in_valid[i] && in_ready[i] at a clock edge.
  - Pointer becomes (i+1) mod NUM_CH.
  - With no accept, the pointer holds.
  - Channels with in_valid=0 are skipped with no penalty cycle.
- Stage 1 on accept:
  - s1_prod = in_pixel[i] * gain[i], full 2*WIDTH bits, unsigned.
  - s1_ch = i, s1_valid = 1.
  - If advance=1 and nothing is accepted: s1_valid = 0.
- Stage 2 when advance:
  - out_valid = s1_valid.
  - out_ch = s1_ch.
  - out_data = clamp(s1_prod >> FRAC_BITS, 0, 2^WIDTH-1). The shifted value is 2*WIDTH-FRAC_BITS bits wide; any set bit above WIDTH-1 saturates to all-ones.
- Latency: an accept at edge N gives out_valid at edge N+2 when there is no stall. Throughput is 1 result per cycle.
- Output hold: while out_valid=1 and out_ready=0, out_data/out_ch/out_valid hold. Stage 1 also holds and in_ready is all zero.
- Gain writes:
  - On an edge with gain_we=1, gain[gain_sel] <= gain_wdata. A gain_sel >= NUM_CH write is ignored.
  - Writes are accepted at any time, including while stalled.
  - A multiply uses the gain value present before the edge of its accept. On a same-edge write plus accept to the same channel, the OLD gain is applied. The new gain applies from the next accept.
- Gain=0 gives out_data=0. Pixel=0 gives 0. No exceptional states.
- Ordering: results leave in accept order. out_ch always matches its pixel's channel.

Test Plan:
- Identity gain: after reset, ch0 in_pixel=0x800 valid for one cycle, out_ready=1 -> out_valid exactly 2 edges later, out_data=0x800, out_ch=0.
- Saturation: write gain[2]=0x200, then ch2 pixel=0xA00 -> 0x1400 clamps to out_data=0xFFF. Also gain[1]=0x080 with pixel=0x7FF -> 0x3FF.
- Round robin: all 3 channels valid continuously for 6 cycles -> grant order 0,1,2,0,1,2 and out_ch sequence 0,1,2,0,1,2 on consecutive cycles. Then drop ch1 -> order 0,2,0,2 with no idle cycles.
- Backpressure: stream on ch0, hold out_ready=0 for 3 cycles mid-stream -> out_data stable, in_ready=0 during the stall, no loss or duplication, order preserved after release.
- Gain write race: gain[0]=0x100, same edge write gain[0]=0x300 and accept pixel 0x100 -> result 0x100. The next accept of 0x100 -> 0x300.
- Reset mid-flight: two accepts in flight, pulse rst_n low asynchronously between edges -> out_valid=0 immediately. Gains return to 0x100. No stale output after release.

Source files
------------

// File: rtl/wb_gain_scheduler_if.sv
// Pixel request, gain programming and result handshake signals of the
// white-balance gain scheduler. The master side is the pixel source plus
// register programmer; the slave side is the scheduler itself.
interface wb_gain_scheduler_if #(
    parameter int NUM_CH = 3,
    parameter int WIDTH  = 12
);
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH*WIDTH-1:0] in_pixel;
    logic [NUM_CH-1:0]       in_ready;
    logic                    gain_we;
    logic [1:0]              gain_sel;
    logic [WIDTH-1:0]        gain_wdata;
    logic                    out_valid;
    logic [WIDTH-1:0]        out_data;
    logic [1:0]              out_ch;
    logic                    out_ready;

    modport master (
        output in_valid, in_pixel, gain_we, gain_sel, gain_wdata, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        input  in_valid, in_pixel, gain_we, gain_sel, gain_wdata, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/wb_gain_scheduler.sv
// White-balance / digital-gain stage: one shared WIDTHxWIDTH multiplier is
// time-multiplexed over NUM_CH pixel channels by a round-robin arbiter.
// Each granted pixel is scaled by its channel gain (unsigned, FRAC_BITS
// fractional bits), saturated to WIDTH bits and passed through a 2-deep
// valid/ready pipeline that stalls as a whole when the output is blocked.
module wb_gain_scheduler #(
    parameter int WIDTH     = 12,
    parameter int FRAC_BITS = 8,
    parameter int NUM_CH    = 3,
    parameter int GAIN_RST  = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    wb_gain_scheduler_if.slave bus
);

    localparam int PW = 2 * WIDTH;

    logic [WIDTH-1:0]  gain [NUM_CH];
    logic [1:0]        rr_ptr;

    logic              s1_valid;
    logic [PW-1:0]     s1_prod;
    logic [1:0]        s1_ch;

    logic              out_valid_q;
    logic [WIDTH-1:0]  out_data_q;
    logic [1:0]        out_ch_q;

    logic              advance;
    logic              accept;
    logic [NUM_CH-1:0] upper_req;
    logic [NUM_CH-1:0] pick_src;
    logic [NUM_CH-1:0] grant;
    logic              grant_any;
    logic [1:0]        grant_idx;
    logic [WIDTH-1:0]  sel_pixel;
    logic [WIDTH-1:0]  sel_gain;
    logic [1:0]        next_ptr;
    logic [PW-1:0]     shifted;
    logic [WIDTH-1:0]  clamped;

    // The whole pipeline moves only when the output register is free to change.
    assign advance = !(out_valid_q && !bus.out_ready);

    // Round-robin arbitration: lowest requester at or above the pointer wins,
    // otherwise wrap around to the lowest requester overall.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        upper_req = '0;
        grant     = '0;
        grant_idx = '0;
        sel_pixel = '0;
        sel_gain  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            upper_req[i] = bus.in_valid[i] && (i >= int'(rr_ptr));
        end
        pick_src  = (|upper_req) ? upper_req : bus.in_valid;
        grant_any = |pick_src;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pick_src[i]) grant_idx = 2'(i);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_any && grant_idx == 2'(i)) begin
                grant[i]  = 1'b1;
                sel_pixel = bus.in_pixel[i*WIDTH +: WIDTH];
                sel_gain  = gain[i];
            end
        end
    end

    // in_ready is held low during reset so no source sees a phantom accept.
    assign accept       = grant_any && advance && rst_n;
    assign bus.in_ready = grant & {NUM_CH{advance && rst_n}};
    assign next_ptr     = (grant_idx == 2'(NUM_CH - 1)) ? 2'd0 : grant_idx + 2'd1;

    // Scale back to integer pixels and saturate anything that overflowed WIDTH bits.
    always_comb begin
        shifted = s1_prod >> FRAC_BITS;
        clamped = (|shifted[PW-1:WIDTH]) ? {WIDTH{1'b1}} : shifted[WIDTH-1:0];
    end

    // Gain register file; same-edge write and accept sees the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the gain file is tiny and must come out of reset at unity, so it is reset like ordinary flops.
            for (int i = 0; i < NUM_CH; i++) gain[i] <= WIDTH'(GAIN_RST);
        end else if (bus.gain_we) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (bus.gain_sel == 2'(i)) gain[i] <= bus.gain_wdata;
            end
        end
    end

    // Round-robin pointer moves past the channel that was just accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (accept) begin
            // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
            rr_ptr <= next_ptr;
        end
    end

    // Stage 1: capture the full-precision product of the accepted pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_prod  <= '0;
            s1_ch    <= '0;
        end else if (advance) begin
            s1_valid <= accept;
            if (accept) begin
                s1_prod <= PW'(sel_pixel) * PW'(sel_gain);
                s1_ch   <= grant_idx;
            end
        end
    end

    // Stage 2: saturated result register facing the demosaic input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else if (advance) begin
            out_valid_q <= s1_valid;
            out_data_q  <= clamped;
            out_ch_q    <= s1_ch;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;

endmodule
